seg7_bcd_counter_mux: RTL and testbench

- Parametrised multi-digit BCD up/down counter with a prescaled tick and a time-multiplexed seven-segment driver.
- Successor to the single-digit seconds display: NUM_DIGITS digits, direction control, parallel load, carry/borrow chaining and wrap flag.
- Sits between the user inputs and the segment/digit-select output pins.

---
 rtl/seg7_bcd_counter_mux.sv | 167 ++++++++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaled tick and multiplexed seven-segment scan.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank digits above the most-significant nonzero digit.
module seg7_bcd_counter_mux #(
   parameter int unsigned           NUM_DIGITS = 4,
   parameter int unsigned           TICK_WIDTH = 24,
   parameter logic [TICK_WIDTH-1:0] MAX_COUNT  = 24'd10_000_000,
   parameter int unsigned           SCAN_DIV   = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      up,
   input  logic [TICK_WIDTH-1:0]     compare_in,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_value,
   output logic [4*NUM_DIGITS-1:0]   count,
   output logic                      tick,
   output logic                      wrap,
   output logic [6:0]                segments,
   output logic [NUM_DIGITS-1:0]     digit_sel
);

   localparam int unsigned CW     = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [TICK_WIDTH-1:0] prescaler;
   logic [TICK_WIDTH-1:0] cmp;
   logic [SCAN_W-1:0]     scan_cnt;
   logic [IDX_W-1:0]      scan_idx;

   logic [CW-1:0]         step_count;
   logic                  step_wrap;
   logic                  ripple;
   logic [3:0]            cur_digit;
   logic [CW-1:0]         load_clamped;

   logic [3:0]            sel_digit;
   logic [NUM_DIGITS-1:0] sel_onehot;
   logic                  blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic                  upper_zero;
`endif

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   assign cmp = (compare_in == '0) ? MAX_COUNT : compare_in;

   // Ripple carry/borrow from digit 0 upward; a ripple surviving past the top digit is a full wrap.
   always_comb begin
      step_count = count;
      ripple     = 1'b1;
      cur_digit  = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         cur_digit = count[4*i +: 4];
         if (ripple) begin
            if (up) begin
               if (cur_digit >= 4'd9) begin
                  step_count[4*i +: 4] = 4'd0;
               end else begin
                  step_count[4*i +: 4] = cur_digit + 4'd1;
                  ripple = 1'b0;
               end
            end else begin
               if (cur_digit == 4'd0) begin
                  step_count[4*i +: 4] = 4'd9;
               end else begin
                  step_count[4*i +: 4] = cur_digit - 4'd1;
                  ripple = 1'b0;
               end
            end
         end
      end
      step_wrap = ripple;
   end

   always_comb begin
      load_clamped = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
      end
   end

   always_comb begin
      sel_digit  = '0;
      sel_onehot = '0;
      blank      = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == scan_idx) begin
            sel_digit     = count[4*i +: 4];
            sel_onehot[i] = 1'b1;
         end
      end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Blank when every digit from the selected one upward is zero; digit 0 always shows.
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) >= scan_idx && count[4*i +: 4] != 4'd0) begin
            upper_zero = 1'b0;
         end
      end
      blank = (scan_idx != '0) && upper_zero;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         count     <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         scan_cnt  <= '0;
         scan_idx  <= '0;
         segments  <= '0;
         digit_sel <= '0;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end

         digit_sel <= sel_onehot;
         segments  <= blank ? 7'h00 : decode(sel_digit);

         // Load takes priority; a step due on the same edge is dropped.
         if (load) begin
            count     <= load_clamped;
            prescaler <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
         end else if (run) begin
            if (prescaler >= cmp) begin
               prescaler <= '0;
               count     <= step_count;
               tick      <= 1'b1;
               wrap      <= step_wrap;
            end else begin
               prescaler <= prescaler + TICK_WIDTH'(1);
               tick      <= 1'b0;
               wrap      <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Self-checking bench for seg7_bcd_counter_mux against a decimal-arithmetic reference model.
module tb_seg7_bcd_counter_mux;

   localparam int ND   = 2;
   localparam int MAXC = 3;
   localparam int SDIV = 2;
   localparam int MOD  = 100;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic          up;
   logic [23:0]   compare_in;
   logic          load;
   logic [4*ND-1:0] load_value;
   logic [4*ND-1:0] count;
   logic          tick;
   logic          wrap;
   logic [6:0]    segments;
   logic [ND-1:0] digit_sel;

   int errors = 0;
   int checks = 0;

   seg7_bcd_counter_mux #(
      .NUM_DIGITS (ND),
      .TICK_WIDTH (24),
      .MAX_COUNT  (24'd3),
      .SCAN_DIV   (SDIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .up         (up),
      .compare_in (compare_in),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .tick       (tick),
      .wrap       (wrap),
      .segments   (segments),
      .digit_sel  (digit_sel)
   );

   always #5 clk = ~clk;

   // Reference model: count held as a plain decimal integer.
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   int         m_val = 0, m_pre = 0, m_scnt = 0, m_sidx = 0;
   logic       m_tick = 1'b0, m_wrap = 1'b0;
   logic [6:0] m_seg = '0;
   logic [ND-1:0] m_sel = '0;

   function automatic int pow10(input int e);
      int r = 1;
      for (int k = 0; k < e; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*ND-1:0] to_bcd(input int v);
      logic [4*ND-1:0] b = '0;
      for (int k = 0; k < ND; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return b;
   endfunction

   function automatic int clamp_dec(input logic [4*ND-1:0] lv);
      int v = 0;
      int n;
      for (int k = 0; k < ND; k++) begin
         n = int'(lv[4*k +: 4]);
         if (n > 9) n = 9;
         v = v + n * pow10(k);
      end
      return v;
   endfunction

   always @(posedge clk) begin
      int c;
      int dig;
      logic blk;
      if (reset) begin
         m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
         m_scnt = 0; m_sidx = 0; m_seg = '0; m_sel = '0;
      end else begin
         dig = (m_val / pow10(m_sidx)) % 10;
         blk = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         blk = (m_sidx != 0) && (m_val < pow10(m_sidx));
`endif
         m_sel = ND'(1) << m_sidx;
         m_seg = blk ? 7'h00 : seg_tab[dig];
         if (m_scnt == SDIV - 1) begin
            m_scnt = 0;
            m_sidx = (m_sidx + 1) % ND;
         end else begin
            m_scnt++;
         end
         c = (compare_in == 0) ? MAXC : int'(compare_in);
         if (load) begin
            m_val = clamp_dec(load_value); m_pre = 0; m_tick = 0; m_wrap = 0;
         end else if (run) begin
            if (m_pre >= c) begin
               m_pre = 0; m_tick = 1;
               if (up) begin
                  m_wrap = (m_val == MOD - 1);
                  m_val  = (m_val + 1) % MOD;
               end else begin
                  m_wrap = (m_val == 0);
                  m_val  = (m_val + MOD - 1) % MOD;
               end
            end else begin
               m_pre++; m_tick = 0; m_wrap = 0;
            end
         end else begin
            m_tick = 0; m_wrap = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 0; load = 0; run = 1; up = 1; compare_in = 0;
      repeat (10) step();
      reset = 1;
      step();
      step();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count act=%h exp=00", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick act=%b exp=0", tick); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap act=%b exp=0", wrap); end
      checks++; if (segments !== 7'h00) begin errors++; $display("FAIL reset_seg act=%h exp=00", segments); end
      checks++; if (digit_sel !== 2'b00) begin errors++; $display("FAIL reset_sel act=%b exp=00", digit_sel); end
      reset = 0;
   endtask

   task automatic test_count_up();
      int ticks = 0;
      int last = 0;
      load = 1; load_value = 8'h00; step();
      load = 0; run = 1; up = 1; compare_in = 0;
      for (int cy = 1; cy <= 40; cy++) begin
         step();
         checks++; if (count !== to_bcd(m_val)) begin errors++; $display("FAIL up_count act=%h exp=%h", count, to_bcd(m_val)); end
         checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap act=%b exp=0", wrap); end
         if (tick === 1'b1) begin
            ticks++;
            checks++; if (cy - last != 4) begin errors++; $display("FAIL up_period act=%0d exp=4", cy - last); end
            last = cy;
            if (ticks == 9) begin
               checks++; if (count !== 8'h09) begin errors++; $display("FAIL up_nine act=%h exp=09", count); end
            end
         end
      end
      checks++; if (ticks != 10) begin errors++; $display("FAIL up_ticks act=%0d exp=10", ticks); end
      checks++; if (count !== 8'h10) begin errors++; $display("FAIL up_ten act=%h exp=10", count); end
   endtask

   task automatic test_wrap();
      logic seen;
      load = 1; load_value = 8'h99; step();
      load = 0; run = 1; up = 1; compare_in = 0;
      seen = 0;
      for (int cy = 0; cy < 10 && !seen; cy++) begin
         step();
         if (tick === 1'b1) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL wrap_up_tick act=none exp=tick"); end
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL wrap_up_count act=%h exp=00", count); end
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_flag act=%b exp=1", wrap); end
      up = 0;
      seen = 0;
      for (int cy = 0; cy < 10 && !seen; cy++) begin
         step();
         if (tick === 1'b1) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL wrap_dn_tick act=none exp=tick"); end
      checks++; if (count !== 8'h99) begin errors++; $display("FAIL wrap_dn_count act=%h exp=99", count); end
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_dn_flag act=%b exp=1", wrap); end
      step();
      checks++; if (wrap !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL wrap_pulse act=%b%b exp=00", tick, wrap); end
   endtask

   task automatic test_load();
      logic found = 0;
      run = 0; load = 1; load_value = 8'h5A; step();
      load = 0;
      checks++; if (count !== 8'h59) begin errors++; $display("FAIL load_clamp act=%h exp=59", count); end
      run = 1; up = 1; compare_in = 0;
      for (int cy = 0; cy < 10 && !found; cy++) begin
         step();
         if (m_pre == MAXC) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL load_align act=none exp=prescaler_at_terminal"); end
      load = 1; load_value = 8'h37; step();
      load = 0;
      checks++; if (count !== 8'h37) begin errors++; $display("FAIL load_on_tick act=%h exp=37", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL load_tick act=%b exp=0", tick); end
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++; if (tick !== (k == 4)) begin errors++; $display("FAIL load_restart k=%0d act=%b exp=%b", k, tick, k == 4); end
      end
      checks++; if (count !== 8'h38) begin errors++; $display("FAIL load_next act=%h exp=38", count); end
   endtask

   task automatic test_compare();
      logic [7:0] held;
      load = 1; load_value = 8'h00; step();
      load = 0; run = 1; up = 1; compare_in = 24'd100;
      for (int cy = 0; cy < 40 && m_pre < 20; cy++) step();
      checks++; if (m_pre != 20 || tick !== 1'b0) begin errors++; $display("FAIL cmp_reach act=%0d/%b exp=20/0", m_pre, tick); end
      compare_in = 24'd5;
      step();
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL cmp_lower act=%b exp=1", tick); end
      checks++; if (count !== 8'h01) begin errors++; $display("FAIL cmp_count act=%h exp=01", count); end
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++; if (tick !== (k == 6)) begin errors++; $display("FAIL cmp_period k=%0d act=%b exp=%b", k, tick, k == 6); end
      end
      step(); step();
      run = 0; held = count;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++; if (count !== held || tick !== 1'b0) begin errors++; $display("FAIL hold k=%0d act=%h/%b exp=%h/0", k, count, tick, held); end
      end
      run = 1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++; if (tick !== (k == 4)) begin errors++; $display("FAIL hold_resume k=%0d act=%b exp=%b", k, tick, k == 4); end
      end
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg;
      run = 0; load = 1; load_value = 8'h42; step();
      load = 0; step();
      for (int k = 0; k < 12; k++) begin
         step();
         checks++; if (digit_sel !== m_sel) begin errors++; $display("FAIL scan_sel act=%b exp=%b", digit_sel, m_sel); end
         exp_seg = (digit_sel == 2'b01) ? 7'h5B : (digit_sel == 2'b10) ? 7'h66 : 7'h7F;
         checks++; if (segments !== exp_seg || digit_sel == 2'b00 || digit_sel == 2'b11) begin
            errors++; $display("FAIL scan_seg sel=%b act=%h exp=%h", digit_sel, segments, exp_seg);
         end
      end
      load = 1; load_value = 8'h07; step();
      load = 0; step();
      for (int k = 0; k < 8; k++) begin
         step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         exp_seg = (digit_sel == 2'b10) ? 7'h00 : 7'h07;
`else
         exp_seg = (digit_sel == 2'b10) ? 7'h3F : 7'h07;
`endif
         checks++; if (segments !== exp_seg) begin errors++; $display("FAIL scan_lz sel=%b act=%h exp=%h", digit_sel, segments, exp_seg); end
      end
   endtask

   task automatic test_random();
      for (int cy = 0; cy < 600; cy++) begin
         reset      = ($urandom_range(0, 99) == 0);
         run        = ($urandom_range(0, 7) != 0);
         up         = $urandom_range(0, 1) == 1;
         compare_in = 24'($urandom_range(0, 4));
         load       = ($urandom_range(0, 15) == 0);
         load_value = 8'($urandom);
         step();
         checks++; if (count !== to_bcd(m_val)) begin errors++; $display("FAIL rnd_count cy=%0d act=%h exp=%h", cy, count, to_bcd(m_val)); end
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL rnd_tick cy=%0d act=%b exp=%b", cy, tick, m_tick); end
         checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap cy=%0d act=%b exp=%b", cy, wrap, m_wrap); end
         checks++; if (segments !== m_seg) begin errors++; $display("FAIL rnd_seg cy=%0d act=%h exp=%h", cy, segments, m_seg); end
         checks++; if (digit_sel !== m_sel) begin errors++; $display("FAIL rnd_sel cy=%0d act=%b exp=%b", cy, digit_sel, m_sel); end
      end
      reset = 0; load = 0;
   endtask

   initial begin
      reset = 1; run = 0; up = 1; compare_in = 0; load = 0; load_value = '0;
      repeat (3) step();
      test_reset();
      test_count_up();
      test_wrap();
      test_load();
      test_compare();
      test_scan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
